axi4_slave_write_arbiter: RTL and testbench
===========================================

AXI4_SLAVE_WRITE_ARBITER -- requirements
Module: axi4_slave_write_arbiter

Interface
REQ-001 Clocking SHALL be one clock, with synchronous active-high reset; ports are aclk and areset.
REQ-002 Parameter NUM_MASTERS, default 9: number of requesting masters.
REQ-003 Parameter TIMEOUT_CYCLES, default 256: W-completion watchdog limit; used only with the macro from REQ-019.
REQ-004 Port aclk, input, 1: clock; all state changes on its rising edge.
REQ-005 Port areset, input, 1: synchronous active-high reset.
REQ-006 Port req, input, NUM_MASTERS: bit m = master m AWVALID qualified by the address decoder selecting this slave.
REQ-007 Port s_awready, input, 1: AWREADY from this slave.
REQ-008 Port w_last_fire, input, 1: WVALID&WREADY&WLAST at this slave for the granted master.
REQ-009 Port grant, output, NUM_MASTERS: one-hot grant, registered.
REQ-010 Port grant_id, output, $clog2(NUM_MASTERS): index of the granted master.
REQ-011 Port grant_valid, output, 1: high while any grant is held.
REQ-012 Port timeout_err, output, 1: one-cycle watchdog pulse; tied 0 without the macro.

Function
REQ-013 The block SHALL use a three-state FSM:
- IDLE: no grant held.
- ADDR: grant held; waiting for the AW handshake.
- DATA: waiting for the W-last handshake.
REQ-014 In IDLE with req != 0, the next cycle SHALL be ADDR, with grant one-hot on the first set req bit searching upward from ptr, wrapping past NUM_MASTERS-1 to 0 (1-cycle latency).
REQ-015 In ADDR, aw_fire = req[grant_id] & s_awready.
- On aw_fire, ptr SHALL become grant_id+1 modulo NUM_MASTERS, so master 8 wraps to 0.
- Grant SHALL hold even if req drops.
REQ-016 A w_last_fire seen in ADDR before aw_fire SHALL set an early-W flag.
- aw_fire with the flag set, or with w_last_fire in the same cycle, SHALL go to IDLE.
- Otherwise aw_fire SHALL go to DATA.
REQ-017 In DATA, w_last_fire SHALL go to IDLE; grant, grant_valid and the early-W flag clear in the same edge.
REQ-018 On return to IDLE, no re-arbitration SHALL occur that cycle, so at least one IDLE cycle separates grants.

Configuration
REQ-019 Macro AXI4_ARB_TIMEOUT_EN SHALL compile the watchdog in or out.
- Defined: a counter increments each cycle in ADDR or DATA and clears on entry to IDLE. When it reaches TIMEOUT_CYCLES-1 without the exit event, timeout_err pulses one cycle and the FSM forces IDLE without updating ptr.
- Undefined: no counter; timeout_err is constant 0; the grant holds indefinitely.

Reset
REQ-020 While areset=1 at a clock edge, all of the following SHALL clear: state=IDLE, grant=0, grant_id=0, grant_valid=0, ptr=0, early-W flag=0, watchdog count=0, timeout_err=0.
REQ-021 Reset mid-transaction (ADDR or DATA) SHALL drop the grant on the same edge; req is ignored in the reset cycle.
REQ-022 The first grant after reset deassertion SHALL be issued no earlier than the second edge.

Structure
REQ-023 Package axi4_arb_pkg SHALL hold:
- the FSM state typedef (IDLE/ADDR/DATA);
- default NUM_MASTERS;
- MID_W = $clog2(NUM_MASTERS).
REQ-024 Sub-module axi4_rr_picker SHALL hold the combinational round-robin search (req, ptr -> one-hot, index, any); the top holds FSM, ptr, flag and watchdog.

Verification
REQ-025 Fairness: req=9'h1FF held; s_awready=1; w_last_fire one cycle after each AW → grants cycle 0,1,...,8,0 in order.
REQ-026 Wrap: ptr=7 after a prior grant to 6; req=9'h101 → grant_id=8; next arbitration → grant_id=0.
REQ-027 Early W: grant to master 3; w_last_fire 2 cycles before s_awready → after aw_fire, state=IDLE directly; DATA never entered.
REQ-028 Simultaneous: aw_fire and w_last_fire in the same cycle → IDLE; grant_valid low the next cycle.
REQ-029 Reset mid-DATA: areset high 1 cycle during DATA with grant_id=5 → all outputs 0 next cycle; ptr=0; req=9'h020 → grant_id=5 two cycles after release.
REQ-030 Watchdog with AXI4_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: grant issued, no w_last_fire → timeout_err pulses exactly one cycle 16 cycles after the grant; grant drops; ptr unchanged.

Source files
------------

// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the AXI4 slave write-channel arbiter.
// Holds the FSM state encoding, default master count and the wrap helper.
package axi4_arb_pkg;

   localparam int NUM_MASTERS_DEF = 9;
   localparam int MID_W           = $clog2(NUM_MASTERS_DEF);

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADDR = 2'd1;
   localparam state_t ST_DATA = 2'd2;

   // (base + off) modulo n, for base < n and off <= n
   function automatic int wrap_add(input int base, input int off, input int n);
      int sum;
      sum = base + off;
      if (sum >= n) sum = sum - n;
      return sum;
   endfunction

endpackage

// File: rtl/axi4_rr_picker.sv
// Combinational round-robin search: first set req bit at or above ptr,
// wrapping past the top master back to 0.
module axi4_rr_picker
   import axi4_arb_pkg::*;
#(
   parameter  int NUM_MASTERS = NUM_MASTERS_DEF,
   localparam int IDW         = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDW-1:0]         ptr,
   output logic [NUM_MASTERS-1:0] onehot,
   output logic [IDW-1:0]         index,
   output logic                   any
);

   int pos;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pos    = 0;
      index  = '0;
      onehot = '0;
      any    = |req;
      // Scan from the farthest offset down so the nearest hit is written last.
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         pos = wrap_add(int'(ptr), i, NUM_MASTERS);
         if (req[pos]) index = IDW'(pos);
      end
      onehot[index] = any;
   end

endmodule

// File: rtl/axi4_slave_write_arbiter.sv
// Per-slave AW/W arbiter: round-robin grant held from AW handshake to W-last.
// Optional W-completion watchdog compiled in with `define AXI4_ARB_TIMEOUT_EN.
module axi4_slave_write_arbiter
   import axi4_arb_pkg::*;
#(
   parameter  int NUM_MASTERS    = NUM_MASTERS_DEF,
   parameter  int TIMEOUT_CYCLES = 256,
   localparam int IDW            = $clog2(NUM_MASTERS)
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   s_awready,
   input  logic                   w_last_fire,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [IDW-1:0]         grant_id,
   output logic                   grant_valid,
   output logic                   timeout_err
);

   state_t                 state;
   logic [IDW-1:0]         ptr;
   logic                   early_w;
   logic                   arb_en;
   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [IDW-1:0]         pick_id;
   logic                   pick_any;
   logic                   aw_fire;
   logic                   wd_fire;

   axi4_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .index  (pick_id),
      .any    (pick_any)
   );

   assign aw_fire = req[grant_id] & s_awready;

`ifdef AXI4_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wd_cnt;
   logic             busy;
   logic             exit_evt;

   assign busy     = (state != ST_IDLE);
   assign exit_evt = ((state == ST_ADDR) && aw_fire && (early_w || w_last_fire)) ||
                     ((state == ST_DATA) && w_last_fire);
   assign wd_fire  = busy && !exit_evt && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts the whole transaction, ADDR through DATA, restarting only in IDLE.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= wd_fire;
         if (!busy || exit_evt || wd_fire) wd_cnt <= '0;
         else                              wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= ST_IDLE;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         ptr         <= '0;
         early_w     <= 1'b0;
         arb_en      <= 1'b0;
      end else begin
         // arb_en holds off arbitration for the first edge after reset release.
         arb_en <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (arb_en && pick_any) begin
                  state       <= ST_ADDR;
                  grant       <= pick_onehot;
                  grant_id    <= pick_id;
                  grant_valid <= 1'b1;
               end
            end
            ST_ADDR: begin
               if (wd_fire) begin
                  state       <= ST_IDLE;
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  early_w     <= 1'b0;
               end else if (aw_fire) begin
                  ptr <= IDW'(wrap_add(int'(grant_id), 1, NUM_MASTERS));
                  if (early_w || w_last_fire) begin
                     state       <= ST_IDLE;
                     grant       <= '0;
                     grant_valid <= 1'b0;
                     early_w     <= 1'b0;
                  end else begin
                     state <= ST_DATA;
                  end
               end else if (w_last_fire) begin
                  early_w <= 1'b1;
               end
            end
            ST_DATA: begin
               if (w_last_fire || wd_fire) begin
                  state       <= ST_IDLE;
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  early_w     <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               grant       <= '0;
               grant_valid <= 1'b0;
               early_w     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_slave_write_arbiter.sv
// Directed self-checking bench for axi4_slave_write_arbiter (9 masters).
// Define AXI4_ARB_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_axi4_slave_write_arbiter;

   localparam int N = 9;
`ifdef AXI4_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 256;
`endif

   logic         aclk = 1'b0;
   logic         areset;
   logic [N-1:0] req;
   logic         s_awready;
   logic         w_last_fire;
   logic [N-1:0] grant;
   logic [3:0]   grant_id;
   logic         grant_valid;
   logic         timeout_err;

   int total = 0;
   int bad   = 0;

   always #5 aclk = ~aclk;

   axi4_slave_write_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
      .aclk        (aclk),
      .areset      (areset),
      .req         (req),
      .s_awready   (s_awready),
      .w_last_fire (w_last_fire),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout_err (timeout_err)
   );

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   // Reset, then one idle edge so the arbiter is ready to grant on the next edge.
   task automatic do_reset;
      areset = 1'b1; req = '0; s_awready = 1'b0; w_last_fire = 1'b0;
      tick;
      areset = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      areset = 1'b1; req = 9'h1FF; s_awready = 1'b0; w_last_fire = 1'b0;
      tick; tick;
      total++; if (grant !== 9'h000) begin bad++; $display("FAIL reset_grant: got %h expected %h", grant, 9'h000); end
      total++; if (grant_id !== 4'd0) begin bad++; $display("FAIL reset_grant_id: got %0d expected %0d", grant_id, 0); end
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_grant_valid: got %b expected %b", grant_valid, 1'b0); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err: got %b expected %b", timeout_err, 1'b0); end
      // Move ptr to 3 with a grant to master 2, then reset and confirm ptr is back at 0.
      areset = 1'b0; req = 9'h004; s_awready = 1'b1; w_last_fire = 1'b1;
      tick;
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_first_edge_nogrant: got %b expected %b", grant_valid, 1'b0); end
      tick;
      total++; if (grant_id !== 4'd2) begin bad++; $display("FAIL reset_grant2: got %0d expected %0d", grant_id, 2); end
      tick;
      areset = 1'b1; req = 9'h1FF;
      tick;
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_again_valid: got %b expected %b", grant_valid, 1'b0); end
      areset = 1'b0; s_awready = 1'b0; w_last_fire = 1'b0;
      tick;
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_release_nogrant: got %b expected %b", grant_valid, 1'b0); end
      tick;
      total++; if (grant_id !== 4'd0) begin bad++; $display("FAIL reset_ptr_zero: got %0d expected %0d", grant_id, 0); end
      total++; if (grant !== 9'h001) begin bad++; $display("FAIL reset_ptr_zero_onehot: got %h expected %h", grant, 9'h001); end
   endtask

   task automatic test_fairness;
      logic [N-1:0] exp_oh;
      int           exp_id;
      do_reset;
      req = 9'h1FF; s_awready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_id = k % N;
         exp_oh = '0;
         exp_oh[exp_id] = 1'b1;
         tick;
         total++; if (grant_id !== 4'(exp_id) || grant !== exp_oh) begin bad++; $display("FAIL fair_grant_%0d: got id=%0d oh=%h expected id=%0d oh=%h", k, grant_id, grant, exp_id, exp_oh); end
         tick;
         w_last_fire = 1'b1;
         tick;
         w_last_fire = 1'b0;
         total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL fair_release_%0d: got %b expected %b", k, grant_valid, 1'b0); end
      end
      req = '0; s_awready = 1'b0;
   endtask

   task automatic test_wrap;
      do_reset;
      req = 9'h040; s_awready = 1'b1;
      tick;
      total++; if (grant_id !== 4'd6) begin bad++; $display("FAIL wrap_grant6: got %0d expected %0d", grant_id, 6); end
      tick;
      req = 9'h101; w_last_fire = 1'b1;
      tick;
      w_last_fire = 1'b0;
      tick;
      total++; if (grant_id !== 4'd8 || grant !== 9'h100) begin bad++; $display("FAIL wrap_grant8: got id=%0d oh=%h expected id=%0d oh=%h", grant_id, grant, 8, 9'h100); end
      tick;
      w_last_fire = 1'b1;
      tick;
      w_last_fire = 1'b0;
      tick;
      total++; if (grant_id !== 4'd0 || grant !== 9'h001) begin bad++; $display("FAIL wrap_grant0: got id=%0d oh=%h expected id=%0d oh=%h", grant_id, grant, 0, 9'h001); end
      req = '0; s_awready = 1'b0;
   endtask

   task automatic test_early_w;
      do_reset;
      req = 9'h008; s_awready = 1'b0;
      tick;
      total++; if (grant_id !== 4'd3) begin bad++; $display("FAIL early_grant3: got %0d expected %0d", grant_id, 3); end
      w_last_fire = 1'b1;
      tick;
      w_last_fire = 1'b0;
      tick;
      total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL early_hold_addr: got %b expected %b", grant_valid, 1'b1); end
      s_awready = 1'b1;
      tick;
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL early_direct_idle: got %b expected %b", grant_valid, 1'b0); end
      s_awready = 1'b0; req = 9'h018;
      tick;
      total++; if (grant_id !== 4'd4) begin bad++; $display("FAIL early_ptr_advance: got %0d expected %0d", grant_id, 4); end
      s_awready = 1'b1;
      tick;
      total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL early_flag_cleared: got %b expected %b", grant_valid, 1'b1); end
      s_awready = 1'b0; w_last_fire = 1'b1;
      tick;
      w_last_fire = 1'b0; req = '0;
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL early_data_release: got %b expected %b", grant_valid, 1'b0); end
   endtask

   task automatic test_simultaneous;
      do_reset;
      req = 9'h004; s_awready = 1'b0;
      tick;
      total++; if (grant_id !== 4'd2) begin bad++; $display("FAIL simul_grant2: got %0d expected %0d", grant_id, 2); end
      s_awready = 1'b1; w_last_fire = 1'b1;
      tick;
      total++; if (grant_valid !== 1'b0 || grant !== 9'h000) begin bad++; $display("FAIL simul_idle: got valid=%b oh=%h expected valid=%b oh=%h", grant_valid, grant, 1'b0, 9'h000); end
      req = '0; s_awready = 1'b0; w_last_fire = 1'b0;
      tick;
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL simul_stay_idle: got %b expected %b", grant_valid, 1'b0); end
   endtask

   task automatic test_reset_mid_data;
      do_reset;
      req = 9'h020; s_awready = 1'b1;
      tick;
      tick;
      s_awready = 1'b0;
      total++; if (grant_valid !== 1'b1 || grant_id !== 4'd5) begin bad++; $display("FAIL rstdata_in_data: got valid=%b id=%0d expected valid=%b id=%0d", grant_valid, grant_id, 1'b1, 5); end
      areset = 1'b1;
      tick;
      total++; if (grant !== 9'h000 || grant_id !== 4'd0 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rstdata_outputs: got oh=%h id=%0d valid=%b to=%b expected all zero", grant, grant_id, grant_valid, timeout_err); end
      areset = 1'b0;
      tick;
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rstdata_one_after: got %b expected %b", grant_valid, 1'b0); end
      tick;
      total++; if (grant_id !== 4'd5 || grant !== 9'h020) begin bad++; $display("FAIL rstdata_two_after: got id=%0d oh=%h expected id=%0d oh=%h", grant_id, grant, 5, 9'h020); end
      req = '0;
   endtask

`ifdef AXI4_ARB_TIMEOUT_EN
   task automatic test_watchdog;
      logic early;
      do_reset;
      req = 9'h010; s_awready = 1'b0;
      tick;
      total++; if (grant_id !== 4'd4) begin bad++; $display("FAIL wd_grant4: got %0d expected %0d", grant_id, 4); end
      early = 1'b0;
      for (int k = 1; k < 16; k++) begin
         tick;
         if (timeout_err || !grant_valid) early = 1'b1;
      end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL wd_not_early: got %b expected %b", early, 1'b0); end
      tick;
      total++; if (timeout_err !== 1'b1 || grant_valid !== 1'b0 || grant !== 9'h000) begin bad++; $display("FAIL wd_pulse: got to=%b valid=%b oh=%h expected to=%b valid=%b oh=%h", timeout_err, grant_valid, grant, 1'b1, 1'b0, 9'h000); end
      req = 9'h030;
      tick;
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_one_cycle: got %b expected %b", timeout_err, 1'b0); end
      total++; if (grant_id !== 4'd4) begin bad++; $display("FAIL wd_ptr_unchanged: got %0d expected %0d", grant_id, 4); end
      req = '0;
   endtask
`else
   task automatic test_watchdog;
      logic seen;
      do_reset;
      req = 9'h002; s_awready = 1'b0;
      tick;
      total++; if (grant_id !== 4'd1) begin bad++; $display("FAIL nowd_grant1: got %0d expected %0d", grant_id, 1); end
      seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick;
         if (timeout_err !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL nowd_no_pulse: got %b expected %b", seen, 1'b0); end
      total++; if (grant_valid !== 1'b1 || grant_id !== 4'd1) begin bad++; $display("FAIL nowd_hold: got valid=%b id=%0d expected valid=%b id=%0d", grant_valid, grant_id, 1'b1, 1); end
      req = '0;
   endtask
`endif

   initial begin
      areset = 1'b1; req = '0; s_awready = 1'b0; w_last_fire = 1'b0;
      test_reset;
      test_fairness;
      test_wrap;
      test_early_w;
      test_simultaneous;
      test_reset_mid_data;
      test_watchdog;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
